// File: rtl/sequence_generator_if.sv
// Board-side bundle of the sequence generator: button/switch inputs,
// serial stream outputs and a debug view of the FSM state.
//
// Stream semantics: bit_stb is a one-clock qualifier on the last clock of
// each bit period. ser_out is stable for the whole period, so a consumer
// samples ser_out whenever bit_stb=1. There is no backpressure: the stream
// is paced only by BIT_CYCLES.
interface sequence_generator_if #(
    parameter int DATA_W = 8
);
    logic              button;
    logic [DATA_W-1:0] switch;
    logic              ser_out;
    logic              bit_stb;
    logic              busy;
    logic              done;
    logic              led;
    logic [1:0]        fsm_state;

    // Generator side: owns the stream outputs.
    modport master (
        input  button, switch,
        output ser_out, bit_stb, busy, done, led, fsm_state
    );

    // Board / consumer side: drives button and switch, watches the stream.
    modport slave (
        output button, switch,
        input  ser_out, bit_stb, busy, done, led, fsm_state
    );
endinterface

// File: rtl/sequence_generator.sv
// Captures the switch pattern on a button press and replays it serially,
// MSB first, each bit held BIT_CYCLES clocks with a per-bit strobe.
module sequence_generator #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sequence_generator_if.master bus
);
    localparam int              BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);
    localparam logic [7:0]      LAST_CYC = 8'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              start;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [7:0]        cyc_cnt;
    logic              bit_end;
    logic              last_bit;

    // Button synchronizer plus an extra flop to find the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start    = sync2 & ~sync3;
    assign bit_end  = (cyc_cnt == LAST_CYC);
    assign last_bit = (bit_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; starts outside IDLE are dropped, not queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (bit_end && last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit/cycle counters; switch is sampled only at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
        end else if (state == IDLE && start) begin
            shreg   <= bus.switch;
            bit_cnt <= '0;
            cyc_cnt <= '0;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                cyc_cnt <= '0;
                if (!last_bit) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end else begin
                cyc_cnt <= cyc_cnt + 8'd1;
            end
        end
    end

    // Outputs decode registered state only, so switch/button never reach them combinationally.
    always_comb begin
        bus.ser_out   = 1'b0;
        bus.bit_stb   = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.led       = 1'b0;
        bus.fsm_state = state;
        case (state)
            SHIFT: begin
                bus.ser_out = shreg[DATA_W-1];
                bus.bit_stb = bit_end;
                bus.busy    = 1'b1;
                bus.led     = shreg[DATA_W-1];
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: one instance with BIT_CYCLES=4 and one with
// BIT_CYCLES=1 share clock, reset, button and switch. A frame-level model
// predicts every output of both instances on every clock.
module tb_sequence_generator;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         button;
  logic [N-1:0] switch;

  sequence_generator_if #(.DATA_W(N)) if4 ();
  sequence_generator_if #(.DATA_W(N)) if1 ();

  assign if4.button = button;
  assign if4.switch = switch;
  assign if1.button = button;
  assign if1.switch = switch;

  sequence_generator #(.DATA_W(N), .BIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.master));
  sequence_generator #(.DATA_W(N), .BIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard bookkeeping.
  int n_checks = 0;
  int n_fail   = 0;

  // Model: frame start edge and captured pattern per instance.
  int           bc[2] = '{4, 1};
  int           fs[2];
  logic [N-1:0] fp[2];
  int           start_at[$];
  logic         btn_prev;
  int           edge_n = 0;

  // Observed per-instance statistics.
  int           busy_cnt[2];
  int           stb_cnt[2];
  int           done_cnt[2];
  logic [N-1:0] bits[2];

  typedef struct {
    logic button;
    logic busy;
    logic ser;
    logic stb;
    logic done;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {busy, ser_out, bit_stb, done, led}
  function automatic logic [4:0] act_vec(input int j);
    if (j == 0) return {if4.busy, if4.ser_out, if4.bit_stb, if4.done, if4.led};
    return {if1.busy, if1.ser_out, if1.bit_stb, if1.done, if1.led};
  endfunction

  // Expected outputs after edge e: frame is N bits of bc clocks each, then one done clock.
  function automatic logic [4:0] model_vec(input int j, input int e);
    int   o;
    logic s;
    logic st;
    if (fs[j] < 0) return 5'b0;
    o = e - fs[j];
    if (o >= 0 && o < N * bc[j]) begin
      s  = fp[j][N - 1 - o / bc[j]];
      st = ((o % bc[j]) == bc[j] - 1);
      return {1'b1, s, st, 1'b0, s};
    end
    if (o == N * bc[j]) return 5'b00010;
    return 5'b0;
  endfunction

  task automatic model_reset();
    fs[0] = -1;
    fs[1] = -1;
    start_at.delete();
    btn_prev = 1'b0;
  endtask

  task automatic clear_stats();
    for (int j = 0; j < 2; j++) begin
      busy_cnt[j] = 0;
      stb_cnt[j]  = 0;
      done_cnt[j] = 0;
      bits[j]     = '0;
    end
  endtask

  // One clock: update model with inputs seen at this edge, then check both DUTs.
  task automatic tick();
    logic [4:0] a;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      if (button && !btn_prev) start_at.push_back(edge_n + 2);
      btn_prev = button;
      if (start_at.size() > 0 && start_at[0] == edge_n) begin
        void'(start_at.pop_front());
        for (int j = 0; j < 2; j++) begin
          if (fs[j] < 0 || edge_n >= fs[j] + N * bc[j] + 2) begin
            fs[j] = edge_n;
            fp[j] = switch;
          end
        end
      end
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      a = act_vec(j);
      chk((j == 0) ? "outputs_bc4" : "outputs_bc1", 32'(a), 32'(model_vec(j, edge_n)));
      if (a[4]) busy_cnt[j]++;
      if (a[2]) begin
        stb_cnt[j]++;
        bits[j] = {bits[j][N-2:0], a[3]};
      end
      if (a[1]) done_cnt[j]++;
    end
  endtask

  task automatic press(input logic [N-1:0] pat);
    switch = pat;
    button = 1'b1;
    tick();
    button = 1'b0;
  endtask

  initial begin
    int hold;

    rst    = 1'b0;
    button = 1'b0;
    switch = '0;
    model_reset();
    clear_stats();

    // Reset state.
    tick();
    tick();
    chk("reset_bc4", 32'(act_vec(0)), 32'h0);
    chk("reset_bc1", 32'(act_vec(1)), 32'h0);
    chk("reset_state", 32'(if4.fsm_state), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();

    // Latency table for the BIT_CYCLES=4 instance; button seen at row 0's edge.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    clear_stats();
    switch = 8'b01101011;
    for (int i = 0; i < 12; i++) begin
      button = tbl[i].button;
      tick();
      chk("latency_table", 32'({if4.busy, if4.ser_out, if4.bit_stb, if4.done}),
          32'({tbl[i].busy, tbl[i].ser, tbl[i].stb, tbl[i].done}));
    end
    button = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("basic_busy_len", 32'(busy_cnt[0]), 32'd32);
    chk("basic_stb_cnt", 32'(stb_cnt[0]), 32'd8);
    chk("basic_done_cnt", 32'(done_cnt[0]), 32'd1);
    chk("basic_bits", 32'(bits[0]), 32'h6B);
    chk("basic_busy_len_bc1", 32'(busy_cnt[1]), 32'd8);
    chk("basic_bits_bc1", 32'(bits[1]), 32'h6B);

    // Second press and switch change during a BIT_CYCLES=4 frame are ignored.
    clear_stats();
    press(8'b11001100);
    for (int i = 0; i < 12; i++) tick();
    switch = 8'b00110100;
    button = 1'b1;
    tick();
    tick();
    button = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("ignore_bits", 32'(bits[0]), 32'hCC);
    chk("ignore_stb_cnt", 32'(stb_cnt[0]), 32'd8);
    chk("ignore_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Held button gives one frame; release and re-press gives another.
    for (int i = 0; i < 5; i++) tick();
    clear_stats();
    switch = 8'b00110100;
    button = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    button = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("held_done_cnt", 32'(done_cnt[0]), 32'd1);
    chk("held_bits", 32'(bits[0]), 32'h34);
    chk("held_done_cnt_bc1", 32'(done_cnt[1]), 32'd1);
    clear_stats();
    press(8'b00110100);
    for (int i = 0; i < 40; i++) tick();
    chk("repress_done_cnt", 32'(done_cnt[0]), 32'd1);
    chk("repress_bits", 32'(bits[0]), 32'h34);

    // Reset after the third strobe: outputs clear before the next edge, no done.
    clear_stats();
    press(8'($urandom_range(0, 255)) | 8'h80);
    for (int t = 0; t < 60 && stb_cnt[0] < 3; t++) tick();
    chk("midreset_reach", 32'(stb_cnt[0]), 32'd3);
    rst = 1'b0;
    #1;
    chk("midreset_async_bc4", 32'(act_vec(0)), 32'h0);
    chk("midreset_async_bc1", 32'(act_vec(1)), 32'h0);
    model_reset();
    clear_stats();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("midreset_no_done", 32'(done_cnt[0]), 32'd0);
    chk("midreset_idle", 32'(busy_cnt[0]), 32'd0);

    // One bit per clock with an all-ones pattern.
    clear_stats();
    press(8'hFF);
    for (int i = 0; i < 15; i++) tick();
    chk("bc1_busy_len", 32'(busy_cnt[1]), 32'd8);
    chk("bc1_stb_cnt", 32'(stb_cnt[1]), 32'd8);
    chk("bc1_bits", 32'(bits[1]), 32'hFF);
    chk("bc1_done_cnt", 32'(done_cnt[1]), 32'd1);
    for (int i = 0; i < 25; i++) tick();

    // Random button levels and switch values against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        button = 1'($urandom_range(0, 1));
        hold   = $urandom_range(1, 40);
      end
      hold--;
      switch = 8'($urandom_range(0, 255));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Transmit-side counterpart of the switch/button sequence detector.
- On a button press, captures the 8-bit switch pattern and replays it as a serial bit stream, MSB first, one bit per BIT_CYCLES clocks.
- The stream carries a per-bit sample strobe so it can drive the detector's serial input directly, or an LED for visual checking.
- Sits between board I/O (button, switches) and the serial consumer.

Parameters:
DATA_W, 8, width of captured pattern and number of bits emitted per frame
BIT_CYCLES, 4, clocks each bit is held on ser_out (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
button  input  1  start request, asynchronous to clk, level
switch  input  DATA_W  pattern to transmit, sampled only at frame start
ser_out  output  1  serial data, MSB first
bit_stb  output  1  one-clock pulse on the last clock of each bit period
busy  output  1  high while a frame is being shifted
done  output  1  one-clock pulse after the final bit period
led  output  1  mirrors ser_out while busy, 0 otherwise

Behaviour:
- Reset (rst=0, async): state=IDLE; shift register, bit counter, cycle counter, synchronizer flops all 0; ser_out=0, bit_stb=0, busy=0, done=0, led=0.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse. After release, the block waits for a new button rising edge.
- button passes through a 2-flop synchronizer plus a third flop for edge detection; start = sync2 & ~sync3.
- Latency: the first clk edge that samples button=1 is edge k. start is high between edges k+1 and k+2. At edge k+2 the FSM leaves IDLE, switch is captured and ser_out drives switch[DATA_W-1].
- FSM states and transitions:
  - IDLE -> SHIFT on start. Load shreg=switch, bit_cnt=0, cyc_cnt=0, busy=1.
  - SHIFT:
    - Each clock, cyc_cnt++.
    - When cyc_cnt==BIT_CYCLES-1: bit_stb=1 for that clock, and cyc_cnt wraps to 0 at the next edge.
    - If bit_cnt<DATA_W-1 at that point: shreg shifts left with 0 fill, bit_cnt++.
    - If bit_cnt==DATA_W-1: go to DONE.
  - DONE: busy=0, ser_out=0, done=1 for exactly one clock, then IDLE.
- ser_out = shreg[DATA_W-1] in SHIFT, 0 in all other states. It is registered: no combinational path from switch or button.
- Frame length: busy high for exactly DATA_W*BIT_CYCLES clocks; exactly DATA_W bit_stb pulses per frame.
- bit_cnt width is clog2(DATA_W); cyc_cnt width is 8 bits. No overflow, because wrap happens at BIT_CYCLES-1.
- start seen in SHIFT or DONE is ignored, not queued.
- A button held high produces one frame only; a new frame needs button low for at least 2 clocks, then high again.
- switch changes during SHIFT have no effect on the current frame.
- BIT_CYCLES=1: bit_stb is high every clock of SHIFT; one bit per clock.

Test Plan:
- Basic frame: rst released, BIT_CYCLES=4, switch=8'b01101011, button pulsed for 1 clock -> busy for 32 clocks. Values of ser_out at the 8 bit_stb pulses are 0,1,1,0,1,0,1,1. done pulses once, 1 clock after busy falls. led tracks ser_out.
- Latency: button rises just before edge k -> busy=1 and ser_out=0 (MSB of 8'b01101011) after edge k+2; first bit_stb at edge k+5 (i.e. between edges k+5 and k+6).
- Ignore-while-busy: start frame with switch=8'b11001100; mid-frame, pulse button again and change switch to 8'b00110100 -> only one frame, bits 1,1,0,0,1,1,0,0; single done pulse.
- Held button: button held high 100 clocks with switch=8'b00110100 -> exactly one frame (bits 0,0,1,1,0,1,0,0). Release button, press again -> second identical frame.
- Reset mid-frame: assert rst=0 after the 3rd bit_stb -> all outputs 0 asynchronously, before the next clk edge; no done pulse. After release, no activity until a new button press.
- BIT_CYCLES=1, switch=8'hFF: busy for 8 clocks, bit_stb high all 8 clocks, ser_out=1 throughout, done pulse at clock 9.
